// File: rtl/tblink_rpc_cmdexec.sv
// Executes one toggle-handshaked RPC command (NOP/WRITE/READ) over an 8-bit register bus.
// Latency: NOP/error 3 edges, bus ops ack edge + 1; holds off upstream via the get index and times out stalled acks.
module tblink_rpc_cmdexec #(
    parameter int CMD_IN_PARAMS_SZ = 4,
    parameter int CMD_IN_RSP_SZ    = 1,
    parameter int TIMEOUT          = 16
) (
    input  logic                          uclock,
    input  logic                          reset,
    input  logic [7:0]                    cmd_in,
    input  logic [7:0]                    cmd_in_sz,
    input  logic [CMD_IN_PARAMS_SZ*8-1:0] cmd_in_params,
    input  logic                          cmd_in_put_i,
    output logic                          cmd_in_get_i,
    output logic [CMD_IN_RSP_SZ*8-1:0]    cmd_in_rsp,
    output logic [7:0]                    cmd_in_rsp_sz,
    output logic [7:0]                    reg_adr,
    output logic [7:0]                    reg_dat_w,
    input  logic [7:0]                    reg_dat_r,
    output logic                          reg_we,
    output logic                          reg_stb,
    input  logic                          reg_ack
);

    localparam int PW  = CMD_IN_PARAMS_SZ * 8;
    localparam int RW  = CMD_IN_RSP_SZ * 8;
    localparam int PXW = (PW > 16) ? PW : 16;
    localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_WRITE  = 8'h01;
    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] RSP_OK    = 8'h00;
    localparam logic [7:0] RSP_BADOP = 8'hFF;
    localparam logic [7:0] RSP_SHORT = 8'hFE;
    localparam logic [7:0] RSP_TMO   = 8'hFD;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        BUS,
        RESP
    } state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       has_byte;
    } rsp_t;

    state_t          state_q, state_d;
    logic [7:0]      op_q, op_d;
    logic [7:0]      sz_q, sz_d;
    logic [PW-1:0]   params_q, params_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      adr_q, adr_d;
    logic [7:0]      dat_w_q, dat_w_d;
    logic            we_q, we_d;
    logic            stb_q, stb_d;
    rsp_t            pend_q, pend_d;
    logic            get_q, get_d;
    logic [RW-1:0]   rsp_q, rsp_d;
    logic [7:0]      rsp_sz_q, rsp_sz_d;

    logic [PXW-1:0]  params_ext;
    logic            unused_params;

    // Widened view so the fixed byte slices below stay legal for narrow parameter buses.
    assign params_ext    = PXW'(params_q);
    assign unused_params = ^params_ext;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sz_d     = sz_q;
        params_d = params_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        dat_w_d  = dat_w_q;
        we_d     = we_q;
        stb_d    = stb_q;
        pend_d   = pend_q;
        get_d    = get_q;
        rsp_d    = rsp_q;
        rsp_sz_d = rsp_sz_q;

        case (state_q)
            IDLE: begin
                if (cmd_in_put_i != get_q) begin
                    op_d     = cmd_in;
                    sz_d     = cmd_in_sz;
                    params_d = cmd_in_params;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                state_d = RESP;
                case (op_q)
                    OP_NOP: begin
                        pend_d = '{code: RSP_OK, has_byte: 1'b0};
                    end
                    OP_WRITE: begin
                        if (sz_q >= 8'd2) begin
                            adr_d   = params_ext[7:0];
                            dat_w_d = params_ext[15:8];
                            we_d    = 1'b1;
                            stb_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = BUS;
                        end else begin
                            pend_d = '{code: RSP_SHORT, has_byte: 1'b1};
                        end
                    end
                    OP_READ: begin
                        if (sz_q >= 8'd1) begin
                            adr_d   = params_ext[7:0];
                            we_d    = 1'b0;
                            stb_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = BUS;
                        end else begin
                            pend_d = '{code: RSP_SHORT, has_byte: 1'b1};
                        end
                    end
                    default: begin
                        pend_d = '{code: RSP_BADOP, has_byte: 1'b1};
                    end
                endcase
            end
            BUS: begin
                // An ack on the final counted cycle still wins over the timeout.
                if (reg_ack) begin
                    stb_d   = 1'b0;
                    state_d = RESP;
                    if (we_q) begin
                        pend_d = '{code: RSP_OK, has_byte: 1'b0};
                    end else begin
                        pend_d = '{code: reg_dat_r, has_byte: 1'b1};
                    end
                end else if (cnt_q == CNT_LAST) begin
                    stb_d   = 1'b0;
                    state_d = RESP;
                    pend_d  = '{code: RSP_TMO, has_byte: 1'b1};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                get_d    = ~get_q;
                rsp_d    = pend_q.has_byte ? RW'(pend_q.code) : '0;
                rsp_sz_d = {7'd0, pend_q.has_byte};
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge uclock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            sz_q     <= '0;
            params_q <= '0;
            cnt_q    <= '0;
            adr_q    <= '0;
            dat_w_q  <= '0;
            we_q     <= 1'b0;
            stb_q    <= 1'b0;
            pend_q   <= '0;
            get_q    <= 1'b0;
            rsp_q    <= '0;
            rsp_sz_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sz_q     <= sz_d;
            params_q <= params_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            dat_w_q  <= dat_w_d;
            we_q     <= we_d;
            stb_q    <= stb_d;
            pend_q   <= pend_d;
            get_q    <= get_d;
            rsp_q    <= rsp_d;
            rsp_sz_q <= rsp_sz_d;
        end
    end

    assign cmd_in_get_i  = get_q;
    assign cmd_in_rsp    = rsp_q;
    assign cmd_in_rsp_sz = rsp_sz_q;
    assign reg_adr       = adr_q;
    assign reg_dat_w     = dat_w_q;
    assign reg_we        = we_q;
    assign reg_stb       = stb_q;

endmodule

// File: tb/tb_tblink_rpc_cmdexec.sv
// Directed bench for tblink_rpc_cmdexec: per-cycle comparison against a command-level model plus literal pins.
module tb_tblink_rpc_cmdexec;

    localparam int PSZ = 4;
    localparam int RSZ = 1;
    localparam int TMO = 16;

    logic             uclock = 1'b0;
    logic             reset  = 1'b1;
    logic [7:0]       cmd_in = 8'h00;
    logic [7:0]       cmd_in_sz = 8'h00;
    logic [PSZ*8-1:0] cmd_in_params = '0;
    logic             cmd_in_put_i = 1'b1;
    logic             cmd_in_get_i;
    logic [RSZ*8-1:0] cmd_in_rsp;
    logic [7:0]       cmd_in_rsp_sz;
    logic [7:0]       reg_adr;
    logic [7:0]       reg_dat_w;
    logic [7:0]       reg_dat_r = 8'h00;
    logic             reg_we;
    logic             reg_stb;
    logic             reg_ack = 1'b0;

    tblink_rpc_cmdexec #(
        .CMD_IN_PARAMS_SZ(PSZ),
        .CMD_IN_RSP_SZ   (RSZ),
        .TIMEOUT         (TMO)
    ) dut (
        .uclock       (uclock),
        .reset        (reset),
        .cmd_in       (cmd_in),
        .cmd_in_sz    (cmd_in_sz),
        .cmd_in_params(cmd_in_params),
        .cmd_in_put_i (cmd_in_put_i),
        .cmd_in_get_i (cmd_in_get_i),
        .cmd_in_rsp   (cmd_in_rsp),
        .cmd_in_rsp_sz(cmd_in_rsp_sz),
        .reg_adr      (reg_adr),
        .reg_dat_w    (reg_dat_w),
        .reg_dat_r    (reg_dat_r),
        .reg_we       (reg_we),
        .reg_stb      (reg_stb),
        .reg_ack      (reg_ack)
    );

    always #5 uclock = ~uclock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic             chk_en = 1'b0;
    logic             exp_get = 1'b0;
    logic [RSZ*8-1:0] exp_rsp = '0;
    logic [7:0]       exp_rsp_sz = 8'h00;
    logic             exp_stb = 1'b0;
    logic [7:0]       exp_adr = 8'h00;
    logic [7:0]       exp_dat_w = 8'h00;
    logic             exp_we = 1'b0;

    int         put_cyc = 0;
    int         get_cyc = 0;
    int         stb_cnt = 0;
    int         n_tog = 0;
    logic       last_get = 1'b0;
    logic [7:0] obs_adr = 8'h00;
    logic [7:0] obs_dat_w = 8'h00;
    logic       obs_we = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(posedge uclock) cyc <= cyc + 1;

    always @(negedge uclock) begin
        if (chk_en) begin
            check("get", 32'(cmd_in_get_i), 32'(exp_get));
            check("rsp", 32'(cmd_in_rsp), 32'(exp_rsp));
            check("rsp_sz", 32'(cmd_in_rsp_sz), 32'(exp_rsp_sz));
            check("stb", 32'(reg_stb), 32'(exp_stb));
            if (exp_stb) begin
                check("adr", 32'(reg_adr), 32'(exp_adr));
                check("we", 32'(reg_we), 32'(exp_we));
                if (exp_we) check("dat_w", 32'(reg_dat_w), 32'(exp_dat_w));
            end
        end
        if (reg_stb) begin
            if (stb_cnt == 0) begin
                obs_adr   = reg_adr;
                obs_dat_w = reg_dat_w;
                obs_we    = reg_we;
            end
            stb_cnt++;
        end
        if (cmd_in_get_i != last_get) begin
            get_cyc  = cyc;
            last_get = cmd_in_get_i;
            n_tog++;
        end
    end

    // Command-level outcome: does it reach the bus, for how many strobe cycles, and what it answers.
    function automatic void model(input logic [7:0] cmd, input logic [7:0] sz, input int dly,
                                  input logic [7:0] dr, output bit bus, output int nb,
                                  output logic [7:0] rsp, output logic [7:0] rsz);
        bus = 1'b0;
        nb  = 0;
        rsp = 8'hFF;
        rsz = 8'd1;
        if (cmd == 8'h00) begin
            rsp = 8'h00;
            rsz = 8'd0;
        end else if (cmd == 8'h01 || cmd == 8'h02) begin
            if ((cmd == 8'h01 && sz < 8'd2) || (cmd == 8'h02 && sz < 8'd1)) begin
                rsp = 8'hFE;
            end else begin
                bus = 1'b1;
                if (dly < TMO) begin
                    nb  = dly + 1;
                    rsp = (cmd == 8'h01) ? 8'h00 : dr;
                    rsz = (cmd == 8'h01) ? 8'd0 : 8'd1;
                end else begin
                    nb  = TMO;
                    rsp = 8'hFD;
                end
            end
        end
    endfunction

    task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] sz, input logic [31:0] p,
                           input int dly, input logic [7:0] dr, input bit tog);
        bit         bus;
        int         nb;
        logic [7:0] rsp;
        logic [7:0] rsz;
        model(cmd, sz, dly, dr, bus, nb, rsp, rsz);
        @(negedge uclock);
        cmd_in        = cmd;
        cmd_in_sz     = sz;
        cmd_in_params = p;
        reg_dat_r     = dr;
        if (tog) cmd_in_put_i = ~cmd_in_put_i;
        put_cyc = cyc;
        stb_cnt = 0;
        @(posedge uclock); #1;
        @(posedge uclock); #1;
        if (bus) begin
            exp_stb = 1'b1;
            exp_adr = p[7:0];
            exp_we  = (cmd == 8'h01);
            if (cmd == 8'h01) exp_dat_w = p[15:8];
            for (int c = 0; c < nb; c++) begin
                reg_ack = (c == dly);
                @(posedge uclock); #1;
                reg_ack = 1'b0;
            end
            exp_stb = 1'b0;
            // Ack arriving after the timeout, while the block is answering.
            if (dly >= TMO) reg_ack = 1'b1;
        end
        @(posedge uclock); #1;
        reg_ack    = 1'b0;
        exp_get    = ~exp_get;
        exp_rsp    = RSZ*8'(rsp);
        exp_rsp_sz = rsz;
    endtask

    logic [7:0]  bv_cmd [8];
    logic [7:0]  bv_sz  [8];
    logic [31:0] bv_par [8];
    int          bv_dly [8];
    logic [7:0]  bv_dr  [8];

    initial begin
        int t0;
        bv_cmd = '{8'h01, 8'h02, 8'h00, 8'h80, 8'h02, 8'h01, 8'h02, 8'h02};
        bv_sz  = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd1, 8'd3, 8'd0, 8'd2};
        bv_par = '{32'h0000_1122, 32'h0000_0022, 32'h0, 32'h0, 32'h0000_0033,
                   32'h00FF_0044, 32'h0000_0066, 32'h0000_0055};
        bv_dly = '{0, 1, 0, 0, 3, 5, 0, 0};
        bv_dr  = '{8'h00, 8'hC3, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h18};

        // Reset state while put is already 1.
        #12;
        check("rst_get", 32'(cmd_in_get_i), 32'd0);
        check("rst_rsp", 32'(cmd_in_rsp), 32'd0);
        check("rst_rsp_sz", 32'(cmd_in_rsp_sz), 32'd0);
        check("rst_stb", 32'(reg_stb), 32'd0);
        check("rst_we", 32'(reg_we), 32'd0);
        check("rst_adr", 32'(reg_adr), 32'd0);
        check("rst_dat_w", 32'(reg_dat_w), 32'd0);
        @(posedge uclock); #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // put=1 left over from reset is a pending NOP.
        run_cmd(8'h00, 8'd0, 32'h0, 0, 8'h00, 1'b0);
        @(negedge uclock); #1;
        check("post_rst_nop_get", 32'(cmd_in_get_i), 32'd1);
        check("post_rst_nop_lat", 32'(get_cyc - put_cyc), 32'd3);

        run_cmd(8'h01, 8'd2, 32'h0000_A53C, 2, 8'h00, 1'b1);
        @(negedge uclock); #1;
        check("wr_adr", 32'(obs_adr), 32'h3C);
        check("wr_dat_w", 32'(obs_dat_w), 32'hA5);
        check("wr_we", 32'(obs_we), 32'd1);
        check("wr_rsp_sz", 32'(cmd_in_rsp_sz), 32'd0);
        check("wr_stb_cycles", 32'(stb_cnt), 32'd3);
        check("wr_lat", 32'(get_cyc - put_cyc), 32'd6);

        run_cmd(8'h02, 8'd1, 32'h0000_0010, 0, 8'h5A, 1'b1);
        @(negedge uclock); #1;
        check("rd_adr", 32'(obs_adr), 32'h10);
        check("rd_we", 32'(obs_we), 32'd0);
        check("rd_rsp", 32'(cmd_in_rsp), 32'h5A);
        check("rd_rsp_sz", 32'(cmd_in_rsp_sz), 32'd1);
        check("rd_lat", 32'(get_cyc - put_cyc), 32'd4);

        run_cmd(8'h7E, 8'd4, 32'h1234_5678, 0, 8'h00, 1'b1);
        @(negedge uclock); #1;
        check("badop_rsp", 32'(cmd_in_rsp), 32'hFF);
        check("badop_rsp_sz", 32'(cmd_in_rsp_sz), 32'd1);
        check("badop_stb_cycles", 32'(stb_cnt), 32'd0);
        check("badop_lat", 32'(get_cyc - put_cyc), 32'd3);

        run_cmd(8'h02, 8'd0, 32'h0000_0010, 0, 8'h00, 1'b1);
        @(negedge uclock); #1;
        check("rd_short_rsp", 32'(cmd_in_rsp), 32'hFE);
        check("rd_short_stb_cycles", 32'(stb_cnt), 32'd0);

        run_cmd(8'h01, 8'd1, 32'h0000_A53C, 0, 8'h00, 1'b1);
        @(negedge uclock); #1;
        check("wr_short_rsp", 32'(cmd_in_rsp), 32'hFE);
        check("wr_short_stb_cycles", 32'(stb_cnt), 32'd0);

        run_cmd(8'h00, 8'd0, 32'h0, 0, 8'h00, 1'b1);
        @(negedge uclock); #1;
        check("nop_rsp_sz", 32'(cmd_in_rsp_sz), 32'd0);

        run_cmd(8'h02, 8'd1, 32'h0000_0044, 100, 8'h99, 1'b1);
        @(negedge uclock); #1;
        check("tmo_stb_cycles", 32'(stb_cnt), 32'd16);
        check("tmo_rsp", 32'(cmd_in_rsp), 32'hFD);
        check("tmo_rsp_sz", 32'(cmd_in_rsp_sz), 32'd1);
        // Stray acks while idle must leave everything untouched.
        reg_ack = 1'b1;
        repeat (2) @(posedge uclock);
        #1 reg_ack = 1'b0;
        @(negedge uclock); #1;
        check("late_ack_get", 32'(cmd_in_get_i), 32'(exp_get));

        t0 = n_tog;
        for (int i = 0; i < 8; i++) run_cmd(bv_cmd[i], bv_sz[i], bv_par[i], bv_dly[i], bv_dr[i], 1'b1);
        @(negedge uclock); #1;
        check("b2b_toggles", 32'(n_tog - t0), 32'd8);
        check("b2b_last_rsp", 32'(cmd_in_rsp), 32'h18);

        // Reset in the middle of a bus cycle, with get currently 1.
        if (cmd_in_put_i == 1'b0) run_cmd(8'h00, 8'd0, 32'h0, 0, 8'h00, 1'b1);
        @(negedge uclock);
        cmd_in        = 8'h02;
        cmd_in_sz     = 8'd1;
        cmd_in_params = 32'h0000_0077;
        cmd_in_put_i  = ~cmd_in_put_i;
        @(posedge uclock); #1;
        @(posedge uclock); #1;
        exp_stb = 1'b1;
        exp_adr = 8'h77;
        exp_we  = 1'b0;
        @(posedge uclock); #1;
        @(posedge uclock); #3;
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("mid_rst_stb", 32'(reg_stb), 32'd0);
        check("mid_rst_get", 32'(cmd_in_get_i), 32'd0);
        check("mid_rst_rsp_sz", 32'(cmd_in_rsp_sz), 32'd0);
        exp_stb    = 1'b0;
        exp_get    = 1'b0;
        exp_rsp    = '0;
        exp_rsp_sz = 8'h00;
        @(posedge uclock); #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (4) @(posedge uclock);
        #1;
        run_cmd(8'h02, 8'd1, 32'h0000_0021, 1, 8'hE7, 1'b1);
        @(negedge uclock); #1;
        check("recover_rsp", 32'(cmd_in_rsp), 32'hE7);
        check("recover_get", 32'(cmd_in_get_i), 32'd1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
